trigger_capture: RTL

TRIGGER_CAPTURE -- requirements
Module: trigger_capture

---
 rtl/trigger_capture.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/trigger_capture.sv
// Triggered ring-buffer capture: pre-trigger history plus post-trigger window,
// then ordered valid/ready readout of the whole buffer.
module trigger_capture #(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned PRE_TRIG = 64
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic [7:0] iData,
  input  logic       iData_Valid,
  input  logic [7:0] iLevel,
  input  logic       iRising,
  input  logic       iArm,
  output logic [7:0] oRd_Data,
  output logic       oRd_Valid,
  input  logic       iRd_Ready,
  output logic       oArmed,
  output logic       oTriggered,
  output logic       oDone
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_TRIG - 1);
  localparam logic [CW-1:0] POST_LAST = CW'(DEPTH - PRE_TRIG - 1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

  typedef enum logic [2:0] {sIdle, sPrefill, sWaitTrig, sPost, sReadout} stateT;

  stateT state, stateNext;

  logic [AW-1:0] wp, startAddr, rdAddr;
  logic [CW-1:0] capCnt, issueCnt, xferCnt;
  logic [7:0]    prev;
  logic          prevValid;

  logic [7:0]    mem [DEPTH];
  logic [7:0]    ramQ;
  logic          rdPend;
  logic [7:0]    skidData;
  logic          skidValid;

  logic          armed_c, wrEn_c, cross_c, trig_c, pop_c, lastPop_c, issue_c;
  logic [1:0]    occAfter_c;

  always_comb begin
    armed_c = (state == sPrefill) || (state == sWaitTrig) || (state == sPost);
    wrEn_c  = armed_c && iData_Valid;
    if (iRising) cross_c = (prev < iLevel) && (iData >= iLevel);
    else         cross_c = (prev > iLevel) && (iData <= iLevel);
    trig_c     = (state == sWaitTrig) && iData_Valid && prevValid && cross_c;
    pop_c      = oRd_Valid && iRd_Ready;
    lastPop_c  = pop_c && (xferCnt == LAST_IDX);
    // Entries held after this cycle's pop plus the read already in flight
    occAfter_c = 2'(oRd_Valid && !iRd_Ready) + 2'(skidValid) + 2'(rdPend);
    issue_c    = (state == sReadout) && (issueCnt < DEPTH_C) && (occAfter_c <= 2'd1);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= sIdle;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      sIdle:     if (iArm) stateNext = sPrefill;
      sPrefill:  if (iData_Valid && (capCnt == PRE_LAST)) stateNext = sWaitTrig;
      sWaitTrig: if (trig_c) stateNext = sPost;
      sPost:     if (iData_Valid && (capCnt == POST_LAST)) stateNext = sReadout;
      sReadout:  if (lastPop_c) stateNext = sIdle;
      default:   stateNext = sIdle;
    endcase
  end

  // Capture side: write pointer, window counter, edge-detect history
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wp        <= '0;
      capCnt    <= '0;
      startAddr <= '0;
      prev      <= '0;
      prevValid <= 1'b0;
    end else if ((state == sIdle) && iArm) begin
      wp        <= '0;
      capCnt    <= '0;
      prevValid <= 1'b0;
    end else if (wrEn_c) begin
      wp        <= wp + AW'(1);
      prev      <= iData;
      prevValid <= 1'b1;
      case (state)
        sPrefill:  capCnt <= (capCnt == PRE_LAST) ? '0 : capCnt + CW'(1);
        sWaitTrig: if (trig_c) begin
                     capCnt    <= CW'(1);
                     startAddr <= wp - AW'(PRE_TRIG);
                   end
        sPost:     capCnt <= (capCnt == POST_LAST) ? '0 : capCnt + CW'(1);
        default:   capCnt <= capCnt;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (wrEn_c)  mem[wp] <= iData;
    if (issue_c) ramQ    <= mem[rdAddr];
  end

  // Readout: RAM read issued ahead into output + skid register pair
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rdAddr    <= '0;
      issueCnt  <= '0;
      xferCnt   <= '0;
      rdPend    <= 1'b0;
      skidData  <= '0;
      skidValid <= 1'b0;
      oRd_Data  <= '0;
      oRd_Valid <= 1'b0;
    end else if (state != sReadout) begin
      rdAddr    <= startAddr;
      issueCnt  <= '0;
      xferCnt   <= '0;
      rdPend    <= 1'b0;
      skidValid <= 1'b0;
      oRd_Valid <= 1'b0;
    end else begin
      rdPend <= issue_c;
      if (issue_c) begin
        rdAddr   <= rdAddr + AW'(1);
        issueCnt <= issueCnt + CW'(1);
      end
      if (pop_c) xferCnt <= xferCnt + CW'(1);
      if (oRd_Valid && !pop_c) begin
        if (rdPend) begin
          skidData  <= ramQ;
          skidValid <= 1'b1;
        end
      end else if (skidValid) begin
        oRd_Data  <= skidData;
        oRd_Valid <= 1'b1;
        skidData  <= ramQ;
        skidValid <= rdPend;
      end else if (rdPend) begin
        oRd_Data  <= ramQ;
        oRd_Valid <= 1'b1;
      end else begin
        oRd_Valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oArmed     <= 1'b0;
      oTriggered <= 1'b0;
      oDone      <= 1'b0;
    end else begin
      oArmed     <= (stateNext == sPrefill) || (stateNext == sWaitTrig) || (stateNext == sPost);
      oTriggered <= (stateNext == sPost) || (stateNext == sReadout);
      oDone      <= lastPop_c;
    end
  end

endmodule
